// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: heading encodings used by input, movement and maze
// logic, plus default timing constants for the player-input stage.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int DEBOUNCE_SAMPLES_DEFAULT = 4;
    localparam int SYNC_STAGES_DEFAULT      = 2;

    // Debounce counter width; covers the full 2..15 sample range.
    localparam int DB_CNT_W = 4;

    // Button slots; the four directions occupy the low bits so they can be sliced.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PAUSE = 4;
    localparam int NUM_BTNS  = 5;

    function automatic dir_e dir_select(input logic [3:0] press, input dir_e cur);
        dir_e sel;
        sel = cur;
        if (press[BTN_UP])
            sel = DIR_UP;
        else if (press[BTN_DOWN])
            sel = DIR_DOWN;
        else if (press[BTN_LEFT])
            sel = DIR_LEFT;
        else if (press[BTN_RIGHT])
            sel = DIR_RIGHT;
        return sel;
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// One button: synchroniser, sample-counting debouncer and single-cycle press pulse
// on each debounced 0->1 transition.
module btn_debouncer
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT,
    parameter int SYNC_STAGES      = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_en,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [DB_CNT_W-1:0] LP_CNT_LAST = DB_CNT_W'(DEBOUNCE_SAMPLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_CNT_W-1:0]    r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sync <= '0;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (i_sample_en) begin
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + DB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stable_d <= 1'b0;
        else
            r_stable_d <= r_stable;
    end

    // Press fires in the cycle after the stable level rises; releases are silent.
    assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/direction_input_ctrl.sv
// Player-input stage: debounces direction/pause buttons, tracks heading and pause,
// and emits one move_tick per game step once a heading exists and play is running.
module direction_input_ctrl
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT,
    parameter int SYNC_STAGES      = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fast_clk,
    input  logic       two_hertz_clk,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       paused,
    output logic       move_tick,
    output logic [1:0] move_dir
);

    logic [SYNC_STAGES-1:0] r_fast_sync;
    logic [SYNC_STAGES-1:0] r_step_sync;
    logic                   r_fast_d;
    logic                   r_step_d;
    logic                   w_sample_en;
    logic                   w_tick_en;

    logic [NUM_BTNS-1:0]    w_btn_raw;
    logic [NUM_BTNS-1:0]    w_press;

    dir_e                   r_dir;
    logic                   r_dir_valid;
    logic                   r_paused;
    logic                   r_move_tick;
    dir_e                   r_move_dir;

    dir_e                   w_dir_next;
    logic                   w_valid_next;
    logic                   w_paused_next;
    logic                   w_fire;

    // The divider outputs are slow data, sampled into clk and edge-detected into strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fast_sync <= '0;
            r_step_sync <= '0;
            r_fast_d    <= 1'b0;
            r_step_d    <= 1'b0;
        end else begin
            r_fast_sync <= {r_fast_sync[SYNC_STAGES-2:0], fast_clk};
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], two_hertz_clk};
            r_fast_d    <= r_fast_sync[SYNC_STAGES-1];
            r_step_d    <= r_step_sync[SYNC_STAGES-1];
        end
    end

    assign w_sample_en = r_fast_sync[SYNC_STAGES-1] & ~r_fast_d;
    assign w_tick_en   = r_step_sync[SYNC_STAGES-1] & ~r_step_d;

    always_comb begin
        w_btn_raw            = '0;
        w_btn_raw[BTN_UP]    = btn_up;
        w_btn_raw[BTN_DOWN]  = btn_down;
        w_btn_raw[BTN_LEFT]  = btn_left;
        w_btn_raw[BTN_RIGHT] = btn_right;
        w_btn_raw[BTN_PAUSE] = btn_pause;
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
            .SYNC_STAGES      (SYNC_STAGES)
        ) u_debouncer (
            .clk         (clk),
            .rst         (rst),
            .i_sample_en (w_sample_en),
            .i_btn       (w_btn_raw[g]),
            .o_press     (w_press[g])
        );
    end

    // Presses are folded in before the step decision so a same-cycle tick sees them.
    always_comb begin
        w_dir_next    = r_dir;
        w_valid_next  = r_dir_valid;
        w_paused_next = r_paused ^ w_press[BTN_PAUSE];
        if (|w_press[BTN_RIGHT:BTN_UP]) begin
            w_dir_next   = dir_select(w_press[BTN_RIGHT:BTN_UP], r_dir);
            w_valid_next = 1'b1;
        end
        w_fire = w_tick_en & w_valid_next & ~w_paused_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir       <= DIR_UP;
            r_dir_valid <= 1'b0;
            r_paused    <= 1'b0;
            r_move_tick <= 1'b0;
            r_move_dir  <= DIR_UP;
        end else begin
            r_dir       <= w_dir_next;
            r_dir_valid <= w_valid_next;
            r_paused    <= w_paused_next;
            r_move_tick <= w_fire;
            if (w_fire)
                r_move_dir <= w_dir_next;
        end
    end

    assign dir       = r_dir;
    assign dir_valid = r_dir_valid;
    assign paused    = r_paused;
    assign move_tick = r_move_tick;
    assign move_dir  = r_move_dir;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Bench for direction_input_ctrl: sample-level debounce model plus a tick scoreboard
// keyed by the cycle each move_tick is due.
module tb_direction_input_ctrl;
    import pacman_pkg::*;

    localparam int N = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       fast_clk;
    logic       two_hertz_clk;
    logic       btn_up, btn_down, btn_left, btn_right, btn_pause;
    logic [1:0] dir;
    logic       dir_valid;
    logic       paused;
    logic       move_tick;
    logic [1:0] move_dir;

    direction_input_ctrl #(
        .DEBOUNCE_SAMPLES (N),
        .SYNC_STAGES      (S)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fast_clk      (fast_clk),
        .two_hertz_clk (two_hertz_clk),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_pause     (btn_pause),
        .dir           (dir),
        .dir_valid     (dir_valid),
        .paused        (paused),
        .move_tick     (move_tick),
        .move_dir      (move_dir)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [1:0] d;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_chk;
    int         n_pass;
    bit         pend_fast, pend_two;
    int         fast_cyc, two_cyc;
    int         m_run[5];
    bit         m_stable[5];
    logic [1:0] m_dir;
    bit         m_valid, m_paused;
    logic [1:0] m_move_dir;
    bit         t_on;
    int         t_due;
    logic [1:0] t_old_dir, t_new_dir;
    bit         t_old_valid, t_old_paused, t_new_paused;

    task automatic check_val(input string tag, input int act, input int expv);
        n_chk++;
        if (act == expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expv, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_run[i]    = 0;
            m_stable[i] = 1'b0;
        end
        m_dir      = 2'd0;
        m_valid    = 1'b0;
        m_paused   = 1'b0;
        m_move_dir = 2'd0;
        sb.delete();
        pend_fast  = 1'b0;
        pend_two   = 1'b0;
        t_on       = 1'b0;
    endtask

    // One debounce sample of every button, as the DUT sees the levels on that fast_clk rise.
    task automatic model_sample(input int p);
        bit lvl[5];
        bit prs[5];
        lvl[0] = btn_up;
        lvl[1] = btn_down;
        lvl[2] = btn_left;
        lvl[3] = btn_right;
        lvl[4] = btn_pause;
        for (int i = 0; i < 5; i++) begin
            prs[i] = 1'b0;
            m_run[i] = (lvl[i] != m_stable[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == N) begin
                m_stable[i] = lvl[i];
                m_run[i]    = 0;
                prs[i]      = lvl[i];
            end
        end
        if (prs[0] || prs[1] || prs[2] || prs[3] || prs[4]) begin
            t_on         = 1'b1;
            t_due        = p + S + 2;
            t_old_dir    = m_dir;
            t_old_valid  = m_valid;
            t_old_paused = m_paused;
            if (prs[0])      m_dir = 2'd0;
            else if (prs[1]) m_dir = 2'd1;
            else if (prs[2]) m_dir = 2'd2;
            else if (prs[3]) m_dir = 2'd3;
            if (prs[0] || prs[1] || prs[2] || prs[3])
                m_valid = 1'b1;
            if (prs[4])
                m_paused = !m_paused;
            t_new_dir    = m_dir;
            t_new_paused = m_paused;
        end
    endtask

    task automatic cycle();
        exp_t e;
        if (pend_fast) begin
            pend_fast = 1'b0;
            if (!rst) model_sample(fast_cyc);
        end
        if (pend_two) begin
            pend_two = 1'b0;
            if (!rst && m_valid && !m_paused)
                sb.push_back('{two_cyc + S + 1, m_dir});
        end
        @(negedge clk);
        cyc++;
        if (cyc % 50 == 0) begin
            fast_clk = ~fast_clk;
            if (fast_clk) begin
                pend_fast = 1'b1;
                fast_cyc  = cyc;
            end
        end
        if (cyc % 2000 == 51) begin
            two_hertz_clk = ~two_hertz_clk;
            if (two_hertz_clk) begin
                pend_two = 1'b1;
                two_cyc  = cyc;
            end
        end
        if (move_tick) begin
            if (sb.size() == 0) begin
                check_val("tick_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("tick_cycle", cyc, e.due);
                check_val("tick_dir", int'(move_dir), int'(e.d));
                m_move_dir = e.d;
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check_val("tick_missed", 0, sb[0].due);
            void'(sb.pop_front());
        end
        if (t_on && cyc == t_due - 1) begin
            check_val("pre_dir", int'(dir), int'(t_old_dir));
            check_val("pre_valid", int'(dir_valid), int'(t_old_valid));
            check_val("pre_paused", int'(paused), int'(t_old_paused));
        end
        if (t_on && cyc == t_due) begin
            check_val("post_dir", int'(dir), int'(t_new_dir));
            check_val("post_valid", int'(dir_valid), int'(m_valid));
            check_val("post_paused", int'(paused), int'(t_new_paused));
            t_on = 1'b0;
        end
        if (cyc % 100 == 49) begin
            check_val("dir", int'(dir), int'(m_dir));
            check_val("dir_valid", int'(dir_valid), int'(m_valid));
            check_val("paused", int'(paused), int'(m_paused));
            check_val("move_dir", int'(move_dir), int'(m_move_dir));
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dir"}, int'(dir), 0);
        check_val({tag, "_valid"}, int'(dir_valid), 0);
        check_val({tag, "_paused"}, int'(paused), 0);
        check_val({tag, "_tick"}, int'(move_tick), 0);
        check_val({tag, "_move_dir"}, int'(move_dir), 0);
    endtask

    initial begin
        bit got_tick;
        cyc = 0; n_chk = 0; n_pass = 0;
        rst = 1'b0; fast_clk = 1'b0; two_hertz_clk = 1'b0;
        btn_up = 1'b1; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_pause = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #1 check_all_zero("rst_hold");

        // Reset release with up held: heading UP becomes valid after four samples.
        run_to(210);
        rst = 1'b0;
        run_to(610);
        btn_up = 1'b0;
        // Left glitch lasting three samples, then a real four-sample press.
        btn_left = 1'b1;
        run_to(910);
        btn_left = 1'b0;
        run_to(1010);
        btn_left = 1'b1;
        run_to(1510);
        btn_left = 1'b0;

        // Fresh reset, then down+right together: down wins, then steady ticks.
        run_to(1610);
        rst = 1'b1;
        model_reset();
        #1 check_all_zero("rst_second");
        run_to(1710);
        rst = 1'b0;
        btn_down = 1'b1; btn_right = 1'b1;
        run_to(2510);
        btn_down = 1'b0; btn_right = 1'b0;

        // Right press whose debounced event coincides with tick_en.
        run_to(11710);
        btn_right = 1'b1;
        run_to(12110);
        btn_right = 1'b0;
        // Pause, three silent steps, then unpause colliding with tick_en.
        btn_pause = 1'b1;
        run_to(12510);
        btn_pause = 1'b0;
        run_to(27710);
        btn_pause = 1'b1;
        run_to(28110);
        btn_pause = 1'b0;

        // Reset during a move_tick pulse.
        run_to(30000);
        got_tick = 1'b0;
        for (int i = 0; i < 5000 && !got_tick; i++) begin
            cycle();
            got_tick = move_tick;
        end
        if (!got_tick) begin
            check_val("wait_tick_timeout", 0, 1);
        end else begin
            #1 rst = 1'b1;
            model_reset();
            #1 check_all_zero("rst_mid_tick");
        end
        run_to(32110);
        rst = 1'b0;
        run_to(36210);
        btn_up = 1'b1;
        run_to(36610);
        btn_up = 1'b0;
        run_to(40200);

        check_val("ticks_outstanding", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/direction_input_ctrl.md
Name: direction_input_ctrl

Overview:
Player-input stage directly downstream of clock_divider. It consumes the divider's fast_clk (400 Hz) as a debounce sample strobe and two_hertz_clk as the game-step strobe. It debounces four direction buttons and one pause button, latches the current Pac-Man heading and emits a one-cycle move_tick per game step to the movement/maze logic. All logic runs on the 100 MHz clk; the divider outputs are treated as data, never as clocks.

Parameters:
DEBOUNCE_SAMPLES, 4, consecutive fast_clk samples of a changed level required before the debounced level follows (legal range 2..15)
SYNC_STAGES, 2, flip-flop depth of every input synchroniser (legal range 2..3)

Ports:
clk  input  1  system clock, 100 MHz; the only clock in the block
rst  input  1  asynchronous, active-high reset
fast_clk  input  1  400 Hz square wave from clock_divider; debounce sample strobe
two_hertz_clk  input  1  2 Hz square wave from clock_divider; game-step strobe
btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high buttons
btn_pause  input  1  raw, asynchronous, active-high pause button
dir  output  2  current heading: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT
dir_valid  output  1  high once any direction has been accepted since reset
paused  output  1  pause state; toggles on each debounced pause press
move_tick  output  1  one-clk pulse per game step while dir_valid && !paused
move_dir  output  2  heading captured with move_tick; held until the next move_tick

Behaviour:
- Reset (asynchronous assert, synchronous release to clk): dir=0, dir_valid=0, paused=0, move_tick=0, move_dir=0. All synchroniser flops, edge detectors, debounce counters and stable levels also reset to 0.
- Each raw input passes through a SYNC_STAGES-deep synchroniser.
- Rising-edge detect on synced fast_clk gives sample_en. Rising-edge detect on synced two_hertz_clk gives tick_en. Each strobe is exactly one clk cycle.
- Debounce, per button, evaluated only on sample_en:
  - If synced level == stable, count clears to 0.
  - If synced level != stable and count == DEBOUNCE_SAMPLES-1, stable takes the synced level and count clears.
  - Otherwise count increments.
  - A glitch shorter than DEBOUNCE_SAMPLES samples never changes stable.
- A press event is a stable 0->1 transition, one clk wide, in the cycle after stable updates. A held button produces only one event. Releases produce no event.
- Direction update on any direction press event:
  - dir takes the pressed direction and dir_valid goes to 1 (sticky until reset).
  - If several press in the same cycle, priority is UP > DOWN > LEFT > RIGHT.
  - Reversals and repeats of the same direction are accepted.
- Pause: each pause press event toggles paused.
- Step: on tick_en, if dir_valid && !paused after this cycle's updates, assert move_tick for exactly one cycle and register move_dir.
- Simultaneous events in the same cycle as tick_en:
  - A direction press is applied first; move_dir carries the new heading.
  - A pause toggle is applied first; pausing suppresses that tick, unpausing allows it.
- No tick is generated before the first direction press.
- Ticks missed while paused are dropped, not queued.
- Latency:
  - From the 2 ns-stable synced edge to dir change: DEBOUNCE_SAMPLES sample_en strobes plus 2 clk.
  - From a two_hertz_clk rising edge to move_tick: SYNC_STAGES+1 clk.
- Reset asserted mid-debounce or mid-pulse: everything clears immediately. After release, a still-held button is re-debounced and then produces a fresh press event.

Decomposition:
- Shared package pacman_pkg holds:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 2-bit encodings (also used by the movement and maze blocks)
  - the default DEBOUNCE_SAMPLES value
- One sub-module, btn_debouncer (synchroniser, counter, stable level, press pulse; parameters DEBOUNCE_SAMPLES and SYNC_STAGES), instantiated five times.
- The fast_clk and two_hertz_clk edge detectors stay in the top level.

Test Plan:
- The bench drives clk at 10 ns period, with fast_clk toggling every 50 clk and two_hertz_clk every 2000 clk (scaled).
- Reset: assert rst with btn_up held -> all outputs 0 immediately. After release, btn_up needs 4 sample_en to set dir=0, dir_valid=1.
- Bounce: pulse btn_left high for 3 sample periods, then low -> dir unchanged, no press event. Hold for 4 sample periods -> dir=2 exactly 2 clk after the 4th sample_en.
- Priority: press btn_down and btn_right simultaneously from dir_valid=0 -> dir=1, then one move_tick per two_hertz_clk rising edge with move_dir=1, each tick 1 clk wide.
- Tick collision: align the debounced btn_right press with tick_en -> that move_tick carries move_dir=3.
- Pause: pause press -> paused=1, no move_tick for 3 game steps. A second pause press coinciding with tick_en -> paused=0 and move_tick asserted that step.
- Mid-operation reset: assert rst during a move_tick pulse -> move_tick drops asynchronously. dir_valid=0 and no ticks afterwards until a new direction press.
